axil_req_arbiter: RTL and testbench
===================================

AXIL_REQ_ARBITER -- requirements
Module: axil_req_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, the width of request and AXI addresses.
REQ-002 SHALL have port ACLK, input, 1 bit: the single clock; all logic is rising-edge.
REQ-003 SHALL have port ARESETN, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port req_valid, input, 2 bits: per-requester command valid.
REQ-005 SHALL have port req_ready, output, 2 bits: per-requester command accept.
REQ-006 SHALL have port req_we, input, 2 bits: 1 = write, 0 = read, per requester.
REQ-007 SHALL have port req_addr, input, 2*ADDR_WIDTH bits: requester n in slice [n*ADDR_WIDTH +: ADDR_WIDTH].
REQ-008 SHALL have port req_wdata, input, 64 bits: requester n in slice [n*32 +: 32].
REQ-009 SHALL have port rsp_valid, output, 2 bits: one-cycle completion pulse, at most one bit set.
REQ-010 SHALL have port rsp_data, output, 32 bits: read data, qualified by rsp_valid.
REQ-011 SHALL have port rsp_err, output, 1 bit: the completing transaction returned SLVERR or DECERR.
REQ-012 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-013 SHALL have the AXI4-Lite master ports m_axi_awaddr[ADDR_WIDTH], m_axi_awvalid, m_axi_wdata[32], m_axi_wstrb[4], m_axi_wvalid, m_axi_bready, m_axi_araddr[ADDR_WIDTH], m_axi_arvalid and m_axi_rready, all outputs.
REQ-014 SHALL have the AXI4-Lite master ports m_axi_awready, m_axi_wready, m_axi_bresp[2], m_axi_bvalid, m_axi_arready, m_axi_rdata[32], m_axi_rresp[2] and m_axi_rvalid, all inputs.

Function
REQ-015 SHALL implement the states IDLE, ADDR, RESP and DONE, with exactly one transaction outstanding at a time.
REQ-016 SHALL, in IDLE, grant one valid requester using round-robin arbitration.
- Single valid requester: it wins.
- Both valid: the requester other than last_grant wins.
REQ-017 SHALL assert req_ready[g] combinationally in IDLE for the winner only.
- On that cycle it captures we, addr and wdata, sets last_grant=g, and goes to ADDR.
REQ-018 SHALL, in ADDR for a write, assert m_axi_awvalid and m_axi_wvalid together, with m_axi_wstrb=4'hF.
- Each valid drops independently after its own handshake and is never re-asserted.
- Goes to RESP on the cycle both handshakes are complete, including a same-cycle completion.
REQ-019 SHALL, in ADDR for a read, assert m_axi_arvalid until m_axi_arready, then go to RESP.
REQ-020 SHALL hold the addr, wdata and valid outputs stable until their handshake completes (AXI rule: no withdrawal).
REQ-021 SHALL, in RESP, assert m_axi_bready (write) or m_axi_rready (read).
- On the bvalid or rvalid handshake it registers the response and goes to DONE.
REQ-022 SHALL, in DONE, pulse rsp_valid[g] for exactly one cycle and return to IDLE.
- rsp_data = captured rdata for a read, 0 for a write.
- rsp_err = resp[1].
REQ-023 SHALL give minimum latency with all slave readies high and the response in the same cycle: accept at cycle T, AXI valids at T+1, RESP at T+2, rsp_valid at T+3.
REQ-024 SHALL not sample a new request in DONE; a requester holding req_valid is re-arbitrated on the next IDLE cycle.
REQ-025 SHALL ignore a requester deasserting req_valid before acceptance, and SHALL not alter a captured command if req_valid changes after acceptance.

Reset
REQ-026 SHALL, while ARESETN is low, immediately drive the following, even mid-transaction:
- all AXI valid and ready outputs, req_ready, rsp_valid, rsp_err and busy to 0;
- rsp_data and all address and data outputs to 0;
- state to IDLE and last_grant to 1, so requester 0 wins the first contention.
REQ-027 SHALL not resume or complete an interrupted transaction after reset release.

Verification
REQ-028 Single write: req0 write to addr 0x4, data 0x00000001, slave always ready, bresp=OKAY.
- m_axi_awaddr=0x4 and m_axi_wdata=0x1 at T+1.
- rsp_valid=2'b01 at T+3, rsp_err=0.
REQ-029 Contention: both requesters hold read requests continuously from reset for 4 transactions.
- Grant order 0,1,0,1.
- Each rsp_valid bit pulses exactly twice.
REQ-030 Channel skew: awready=1, wready delayed 3 cycles.
- m_axi_awvalid high for exactly 1 cycle.
- m_axi_wvalid held 4 cycles with wdata stable.
- Exactly one AW handshake.
REQ-031 Read error: req1 reads 0x8, slave returns rdata=0x00001234, rresp=2'b10.
- rsp_valid=2'b10, rsp_data=0x00001234, rsp_err=1.
REQ-032 Reset in RESP: ARESETN pulsed low while waiting for bvalid.
- All outputs 0 in the same cycle, busy=0.
- A subsequent req1 write completes normally with no stale rsp_valid.

Source files
------------

// File: rtl/axil_req_arbiter.sv
// rtl/axil_req_arbiter.sv - two-requester round-robin front end for a single AXI4-Lite master port
module axil_req_arbiter #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,

    input  logic [1:0]              req_valid,
    output logic [1:0]              req_ready,
    input  logic [1:0]              req_we,
    input  logic [2*ADDR_WIDTH-1:0] req_addr,
    input  logic [63:0]             req_wdata,

    output logic [1:0]              rsp_valid,
    output logic [31:0]             rsp_data,
    output logic                    rsp_err,
    output logic                    busy,

    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [31:0]             m_axi_wdata,
    output logic [3:0]              m_axi_wstrb,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    input  logic [31:0]             m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                  state;
    logic                    last_grant;
    logic                    grant;
    logic                    cmd_we;
    logic [ADDR_WIDTH-1:0]   cmd_addr;
    logic [31:0]             cmd_wdata;
    logic                    awvalid_q;
    logic                    wvalid_q;
    logic                    arvalid_q;
    logic                    bready_q;
    logic                    rready_q;

    logic                    win_any;
    logic                    win_idx;
    logic                    aw_done;
    logic                    w_done;
    logic                    unused_resp_lsb;

    // On contention the requester that did not win last time goes first.
    always_comb begin
        win_any = |req_valid;
        if (&req_valid) begin
            win_idx = ~last_grant;
        end else begin
            win_idx = req_valid[1];
        end
    end

    assign req_ready = (ARESETN && (state == IDLE) && win_any)
                     ? (win_idx ? 2'b10 : 2'b01) : 2'b00;

    // A channel counts as done once its valid has already dropped or handshakes now.
    assign aw_done = !awvalid_q || m_axi_awready;
    assign w_done  = !wvalid_q  || m_axi_wready;

    assign m_axi_awaddr  = cmd_addr;
    assign m_axi_araddr  = cmd_addr;
    assign m_axi_wdata   = cmd_wdata;
    assign m_axi_wstrb   = wvalid_q ? 4'hF : 4'h0;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_bready  = bready_q;
    assign m_axi_rready  = rready_q;
    assign busy          = (state != IDLE);

    assign unused_resp_lsb = m_axi_bresp[0] ^ m_axi_rresp[0];

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            grant      <= 1'b0;
            cmd_we     <= 1'b0;
            cmd_addr   <= '0;
            cmd_wdata  <= '0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            arvalid_q  <= 1'b0;
            bready_q   <= 1'b0;
            rready_q   <= 1'b0;
            rsp_valid  <= 2'b00;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_any) begin
                        grant      <= win_idx;
                        last_grant <= win_idx;
                        cmd_we     <= req_we[win_idx];
                        cmd_addr   <= win_idx ? req_addr[ADDR_WIDTH +: ADDR_WIDTH]
                                              : req_addr[0 +: ADDR_WIDTH];
                        cmd_wdata  <= win_idx ? req_wdata[32 +: 32] : req_wdata[0 +: 32];
                        if (req_we[win_idx]) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                        end else begin
                            arvalid_q <= 1'b1;
                        end
                        state <= ADDR;
                    end
                end
                ADDR: begin
                    if (cmd_we) begin
                        if (awvalid_q && m_axi_awready) begin
                            awvalid_q <= 1'b0;
                        end
                        if (wvalid_q && m_axi_wready) begin
                            wvalid_q <= 1'b0;
                        end
                        if (aw_done && w_done) begin
                            bready_q <= 1'b1;
                            state    <= RESP;
                        end
                    end else if (m_axi_arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (cmd_we && m_axi_bvalid) begin
                        bready_q  <= 1'b0;
                        rsp_data  <= '0;
                        rsp_err   <= m_axi_bresp[1];
                        rsp_valid <= grant ? 2'b10 : 2'b01;
                        state     <= DONE;
                    end else if (!cmd_we && m_axi_rvalid) begin
                        rready_q  <= 1'b0;
                        rsp_data  <= m_axi_rdata;
                        rsp_err   <= m_axi_rresp[1];
                        rsp_valid <= grant ? 2'b10 : 2'b01;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    rsp_valid <= 2'b00;
                    rsp_data  <= '0;
                    rsp_err   <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axil_req_arbiter.sv
// tb/tb_axil_req_arbiter.sv - directed self-checking bench for axil_req_arbiter
module tb_axil_req_arbiter;

    localparam int AW = 32;

    logic          ACLK = 1'b0;
    logic          ARESETN;
    logic [1:0]    req_valid;
    logic [1:0]    req_ready;
    logic [1:0]    req_we;
    logic [2*AW-1:0] req_addr;
    logic [63:0]   req_wdata;
    logic [1:0]    rsp_valid;
    logic [31:0]   rsp_data;
    logic          rsp_err;
    logic          busy;
    logic [AW-1:0] m_axi_awaddr;
    logic          m_axi_awvalid;
    logic          m_axi_awready;
    logic [31:0]   m_axi_wdata;
    logic [3:0]    m_axi_wstrb;
    logic          m_axi_wvalid;
    logic          m_axi_wready;
    logic [1:0]    m_axi_bresp;
    logic          m_axi_bvalid;
    logic          m_axi_bready;
    logic [AW-1:0] m_axi_araddr;
    logic          m_axi_arvalid;
    logic          m_axi_arready;
    logic [31:0]   m_axi_rdata;
    logic [1:0]    m_axi_rresp;
    logic          m_axi_rvalid;
    logic          m_axi_rready;

    int asserts  = 0;
    int failures = 0;

    axil_req_arbiter #(.ADDR_WIDTH(AW)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    always #5 ACLK = ~ACLK;

    task automatic next_cycle();
        @(posedge ACLK);
        #1;
    endtask

    task automatic test_reset();
        ARESETN = 1'b1; req_valid = 2'b00; req_we = 2'b00; req_addr = '0; req_wdata = '0;
        m_axi_awready = 1'b1; m_axi_wready = 1'b1; m_axi_bresp = 2'b00; m_axi_bvalid = 1'b1;
        m_axi_arready = 1'b1; m_axi_rdata = '0; m_axi_rresp = 2'b00; m_axi_rvalid = 1'b1;
        #2;
        ARESETN = 1'b0;
        req_valid = 2'b11;
        next_cycle();
        next_cycle();
        asserts++;
        if (req_ready !== 2'b00) begin
            failures++; $display("FAIL reset_req_ready: got %b expected 00", req_ready);
        end
        asserts++;
        if ({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready} !== 5'b0) begin
            failures++; $display("FAIL reset_axi_handshakes: got %b expected 00000",
                {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready});
        end
        asserts++;
        if ({rsp_valid, rsp_err, busy} !== 4'b0) begin
            failures++; $display("FAIL reset_rsp_busy: got %b expected 0000", {rsp_valid, rsp_err, busy});
        end
        asserts++;
        if ({m_axi_awaddr, m_axi_araddr, m_axi_wdata, m_axi_wstrb, rsp_data} !== '0) begin
            failures++; $display("FAIL reset_data_outputs: awaddr %h araddr %h wdata %h wstrb %h rsp_data %h expected all 0",
                m_axi_awaddr, m_axi_araddr, m_axi_wdata, m_axi_wstrb, rsp_data);
        end
    endtask

    task automatic test_contention();
        int gcnt, rcnt0, rcnt1;
        int order [4];
        int gcyc [4];
        gcnt = 0; rcnt0 = 0; rcnt1 = 0;
        req_we = 2'b00;
        req_addr = {32'h0000_0104, 32'h0000_0100};
        req_valid = 2'b11;
        ARESETN = 1'b1;
        for (int c = 0; c < 60 && (rcnt0 + rcnt1) < 4; c++) begin
            if (c > 0) next_cycle();
            if (gcnt == 4) req_valid = 2'b00;
            #1;
            if (req_ready !== 2'b00) begin
                if (gcnt < 4) begin
                    order[gcnt] = req_ready[1] ? 1 : 0;
                    gcyc[gcnt]  = c;
                end
                gcnt++;
            end
            if (rsp_valid[0] === 1'b1) rcnt0++;
            if (rsp_valid[1] === 1'b1) rcnt1++;
        end
        req_valid = 2'b00;
        asserts++;
        if (gcnt != 4) begin
            failures++; $display("FAIL contention_grant_count: got %0d expected 4", gcnt);
        end else begin
            for (int i = 0; i < 4; i++) begin
                asserts++;
                if (order[i] != (i % 2)) begin
                    failures++; $display("FAIL contention_order[%0d]: got %0d expected %0d", i, order[i], i % 2);
                end
            end
            asserts++;
            if (gcyc[0] != 0 || gcyc[1] != 4 || gcyc[2] != 8 || gcyc[3] != 12) begin
                failures++; $display("FAIL contention_grant_cycles: got %0d %0d %0d %0d expected 0 4 8 12",
                    gcyc[0], gcyc[1], gcyc[2], gcyc[3]);
            end
        end
        asserts++;
        if (rcnt0 != 2 || rcnt1 != 2) begin
            failures++; $display("FAIL contention_rsp_counts: got %0d/%0d expected 2/2", rcnt0, rcnt1);
        end
        next_cycle();
        asserts++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL contention_idle_after: busy %b expected 0", busy);
        end
    endtask

    task automatic test_single_write();
        req_valid = 2'b01; req_we = 2'b01;
        req_addr = {32'h0, 32'h0000_0004}; req_wdata = {32'h0, 32'h0000_0001};
        #1;
        asserts++;
        if (req_ready !== 2'b01) begin
            failures++; $display("FAIL write_accept: req_ready %b expected 01", req_ready);
        end
        next_cycle();
        req_valid = 2'b00;
        req_addr = {32'h0, 32'hDEAD_0000}; req_wdata = {32'h0, 32'hFFFF_FFFF};
        asserts++;
        if (m_axi_awvalid !== 1'b1 || m_axi_wvalid !== 1'b1 || m_axi_wstrb !== 4'hF || busy !== 1'b1) begin
            failures++; $display("FAIL write_t1_valids: awvalid %b wvalid %b wstrb %h busy %b expected 1 1 f 1",
                m_axi_awvalid, m_axi_wvalid, m_axi_wstrb, busy);
        end
        asserts++;
        if (m_axi_awaddr !== 32'h4 || m_axi_wdata !== 32'h1) begin
            failures++; $display("FAIL write_t1_payload: awaddr %h wdata %h expected 4 1", m_axi_awaddr, m_axi_wdata);
        end
        next_cycle();
        asserts++;
        if (m_axi_bready !== 1'b1 || m_axi_awvalid !== 1'b0 || m_axi_wvalid !== 1'b0) begin
            failures++; $display("FAIL write_t2_resp: bready %b awvalid %b wvalid %b expected 1 0 0",
                m_axi_bready, m_axi_awvalid, m_axi_wvalid);
        end
        next_cycle();
        asserts++;
        if (rsp_valid !== 2'b01 || rsp_err !== 1'b0 || rsp_data !== 32'h0) begin
            failures++; $display("FAIL write_t3_rsp: rsp_valid %b err %b data %h expected 01 0 0",
                rsp_valid, rsp_err, rsp_data);
        end
        next_cycle();
        asserts++;
        if (rsp_valid !== 2'b00 || busy !== 1'b0) begin
            failures++; $display("FAIL write_t4_idle: rsp_valid %b busy %b expected 00 0", rsp_valid, busy);
        end
    endtask

    task automatic test_read_error();
        m_axi_rdata = 32'h0000_1234; m_axi_rresp = 2'b10;
        req_valid = 2'b10; req_we = 2'b00;
        req_addr = {32'h0000_0008, 32'h0};
        #1;
        asserts++;
        if (req_ready !== 2'b10) begin
            failures++; $display("FAIL read_accept: req_ready %b expected 10", req_ready);
        end
        next_cycle();
        req_valid = 2'b00;
        asserts++;
        if (m_axi_arvalid !== 1'b1 || m_axi_araddr !== 32'h8 || m_axi_awvalid !== 1'b0) begin
            failures++; $display("FAIL read_t1_ar: arvalid %b araddr %h awvalid %b expected 1 8 0",
                m_axi_arvalid, m_axi_araddr, m_axi_awvalid);
        end
        next_cycle();
        asserts++;
        if (m_axi_rready !== 1'b1) begin
            failures++; $display("FAIL read_t2_rready: got %b expected 1", m_axi_rready);
        end
        next_cycle();
        asserts++;
        if (rsp_valid !== 2'b10 || rsp_data !== 32'h0000_1234 || rsp_err !== 1'b1) begin
            failures++; $display("FAIL read_t3_rsp: rsp_valid %b data %h err %b expected 10 00001234 1",
                rsp_valid, rsp_data, rsp_err);
        end
        next_cycle();
        m_axi_rresp = 2'b00;
    endtask

    task automatic test_channel_skew();
        int awc, awhs, wc, wbad, rsp_k;
        awc = 0; awhs = 0; wc = 0; wbad = 0; rsp_k = 0;
        m_axi_awready = 1'b1; m_axi_wready = 1'b0;
        req_valid = 2'b01; req_we = 2'b01;
        req_addr = {32'h0, 32'h0000_0010}; req_wdata = {32'h0, 32'hA5A5_0001};
        #1;
        asserts++;
        if (req_ready !== 2'b01) begin
            failures++; $display("FAIL skew_accept: req_ready %b expected 01", req_ready);
        end
        for (int k = 1; k <= 8; k++) begin
            next_cycle();
            if (k == 1) req_valid = 2'b00;
            m_axi_wready = (k >= 4);
            #1;
            if (m_axi_awvalid === 1'b1) awc++;
            if (m_axi_awvalid === 1'b1 && m_axi_awready === 1'b1) awhs++;
            if (m_axi_wvalid === 1'b1) begin
                wc++;
                if (m_axi_wdata !== 32'hA5A5_0001) wbad++;
            end
            if (rsp_valid === 2'b01) rsp_k = k;
        end
        m_axi_wready = 1'b1;
        asserts++;
        if (awc != 1 || awhs != 1) begin
            failures++; $display("FAIL skew_aw: awvalid cycles %0d handshakes %0d expected 1 1", awc, awhs);
        end
        asserts++;
        if (wc != 4 || wbad != 0) begin
            failures++; $display("FAIL skew_w: wvalid cycles %0d unstable %0d expected 4 0", wc, wbad);
        end
        asserts++;
        if (rsp_k != 6) begin
            failures++; $display("FAIL skew_rsp_cycle: got %0d expected 6", rsp_k);
        end
    endtask

    task automatic test_reset_in_resp();
        int rcount, rsp_k, wrong;
        rcount = 0; rsp_k = 0; wrong = 0;
        m_axi_bvalid = 1'b0;
        req_valid = 2'b01; req_we = 2'b01;
        req_addr = {32'h0, 32'h0000_0030}; req_wdata = {32'h0, 32'h1111_2222};
        next_cycle();
        req_valid = 2'b00;
        next_cycle();
        next_cycle();
        asserts++;
        if (m_axi_bready !== 1'b1 || busy !== 1'b1) begin
            failures++; $display("FAIL rstresp_waiting: bready %b busy %b expected 1 1", m_axi_bready, busy);
        end
        ARESETN = 1'b0;
        req_valid = 2'b10; req_we = 2'b10;
        #1;
        asserts++;
        if ({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready,
             req_ready, rsp_valid, rsp_err, busy} !== 11'b0) begin
            failures++; $display("FAIL rstresp_ctrl_zero: got %b expected 0",
                {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready,
                 req_ready, rsp_valid, rsp_err, busy});
        end
        asserts++;
        if ({m_axi_awaddr, m_axi_araddr, m_axi_wdata, m_axi_wstrb, rsp_data} !== '0) begin
            failures++; $display("FAIL rstresp_data_zero: awaddr %h wdata %h wstrb %h rsp_data %h expected 0",
                m_axi_awaddr, m_axi_wdata, m_axi_wstrb, rsp_data);
        end
        m_axi_bvalid = 1'b1;
        next_cycle();
        next_cycle();
        req_addr = {32'h0000_0020, 32'h0}; req_wdata = {32'h0000_CAFE, 32'h0};
        ARESETN = 1'b1;
        #1;
        asserts++;
        if (req_ready !== 2'b10 || rsp_valid !== 2'b00) begin
            failures++; $display("FAIL rstresp_new_accept: req_ready %b rsp_valid %b expected 10 00", req_ready, rsp_valid);
        end
        for (int k = 1; k <= 6; k++) begin
            next_cycle();
            if (k == 1) begin
                req_valid = 2'b00;
                if (m_axi_awaddr !== 32'h20 || m_axi_wdata !== 32'h0000_CAFE) wrong++;
            end
            if (rsp_valid !== 2'b00) begin
                rcount++;
                rsp_k = k;
                if (rsp_valid !== 2'b10 || rsp_err !== 1'b0) wrong++;
            end
        end
        asserts++;
        if (rcount != 1 || rsp_k != 3 || wrong != 0) begin
            failures++; $display("FAIL rstresp_followup: rsp count %0d at cycle %0d bad %0d expected 1 3 0",
                rcount, rsp_k, wrong);
        end
    endtask

    initial begin
        test_reset();
        next_cycle();
        test_contention();
        test_single_write();
        test_read_error();
        test_channel_skew();
        test_reset_in_resp();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule
